// File: rtl/game_match_ctrl.sv
// game_match_ctrl: best-of-ROUNDS match sequencer above fsm_game.
// Ports: clk_i, a_rst_n_i, start/shot strobes, game_pause_i, frac_i -> strobes, score, display.
module game_match_ctrl #(
  parameter int ROUNDS         = 5,
  parameter int FRAC_LIM       = 100,
  parameter int SCORE_HW_TICKS = 150_000_000
) (
  input  logic       clk_i,
  input  logic       a_rst_n_i,
  input  logic       start_stb_i,
  input  logic       shot_stb_i,
  input  logic       game_pause_i,
  input  logic [6:0] frac_i,
  output logic       game_res_stb_o,
  output logic       game_btn_stb_o,
  output logic [3:0] round_o,
  output logic [3:0] hits_o,
  output logic [6:0] best_dist_o,
  output logic [9:0] total_dist_o,
  output logic       show_score_o,
  output logic       match_done_o
);

  localparam int TW =
    (SCORE_HW_TICKS > 1) ? $clog2(SCORE_HW_TICKS) : 1;
  localparam logic [TW-1:0] TICK_LAST =
    TW'(SCORE_HW_TICKS - 1);
  localparam logic [3:0] RND_LAST = 4'(ROUNDS);
  localparam logic [7:0] LIM = 8'(FRAC_LIM);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_RUNNING,
    S_HOLD,
    S_SCORE,
    S_DONE
  } state_t;

  state_t        r_state, w_state;
  logic          r_pause_prev;
  logic [TW-1:0] r_tick, w_tick;
  logic          w_res, w_btn, w_show, w_done;
  logic [3:0]    w_round, w_hits;
  logic [6:0]    w_best;
  logic [9:0]    w_total;

  logic          w_rise, w_fall;
  logic [7:0]    w_f, w_comp;
  logic [6:0]    w_dist;

  assign w_rise = game_pause_i & ~r_pause_prev;
  assign w_fall = ~game_pause_i & r_pause_prev;

  // Clamp out-of-range stopwatch values, then take the
  // distance to the nearer wrap point (0 or FRAC_LIM).
  assign w_f    = ({1'b0, frac_i} >= LIM) ?
                  (LIM - 8'd1) : {1'b0, frac_i};
  assign w_comp = LIM - w_f;
  assign w_dist = (w_f < w_comp) ? w_f[6:0] : w_comp[6:0];

  always_comb begin
    w_state = r_state;
    w_tick  = r_tick;
    w_res   = 1'b0;
    w_btn   = 1'b0;
    w_round = round_o;
    w_hits  = hits_o;
    w_best  = best_dist_o;
    w_total = total_dist_o;
    if (start_stb_i) begin
      // Restart beats any shot or pause edge this cycle.
      w_state = S_ARMED;
      w_res   = 1'b1;
      w_round = 4'd0;
      w_hits  = 4'd0;
      w_best  = 7'h7F;
      w_total = 10'd0;
    end else begin
      unique case (r_state)
        S_IDLE: ;
        S_ARMED: begin
          if (shot_stb_i) begin
            w_btn   = 1'b1;
            w_state = S_RUNNING;
          end
        end
        S_RUNNING: begin
          w_btn = shot_stb_i;
          if (w_rise) begin
            w_state = S_HOLD;
            w_total = total_dist_o + 10'(w_dist);
            if (w_dist < best_dist_o)
              w_best = w_dist;
            if (w_dist == 7'd0 && hits_o < RND_LAST)
              w_hits = hits_o + 4'd1;
          end
        end
        S_HOLD: begin
          if (w_fall) begin
            if (round_o < RND_LAST)
              w_round = round_o + 4'd1;
            if (w_round == RND_LAST) begin
              w_state = S_SCORE;
              w_tick  = '0;
            end else begin
              w_state = S_RUNNING;
            end
          end
        end
        S_SCORE: begin
          if (r_tick == TICK_LAST)
            w_state = S_DONE;
          else
            w_tick = r_tick + 1'b1;
        end
        S_DONE: ;
        default: w_state = S_IDLE;
      endcase
    end
    w_show = (w_state == S_SCORE);
    w_done = (w_state == S_DONE);
  end

  always_ff @(posedge clk_i or negedge a_rst_n_i) begin
    if (!a_rst_n_i) begin
      r_state        <= S_IDLE;
      r_pause_prev   <= 1'b0;
      r_tick         <= '0;
      game_res_stb_o <= 1'b0;
      game_btn_stb_o <= 1'b0;
      round_o        <= 4'd0;
      hits_o         <= 4'd0;
      best_dist_o    <= 7'h7F;
      total_dist_o   <= 10'd0;
      show_score_o   <= 1'b0;
      match_done_o   <= 1'b0;
    end else begin
      r_state        <= w_state;
      r_pause_prev   <= game_pause_i;
      r_tick         <= w_tick;
      game_res_stb_o <= w_res;
      game_btn_stb_o <= w_btn;
      round_o        <= w_round;
      hits_o         <= w_hits;
      best_dist_o    <= w_best;
      total_dist_o   <= w_total;
      show_score_o   <= w_show;
      match_done_o   <= w_done;
    end
  end

endmodule

// File: tb/tb_game_match_ctrl.sv
// tb_game_match_ctrl: directed bench for game_match_ctrl
// ROUNDS=3, FRAC_LIM=100, SCORE_HW_TICKS=10.
module tb_game_match_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, shot, pause;
  logic [6:0] frac;
  logic       res_o, btn_o, show_o, done_o;
  logic [3:0] round_o, hits_o;
  logic [6:0] best_o;
  logic [9:0] total_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  game_match_ctrl #(
    .ROUNDS(3),
    .FRAC_LIM(100),
    .SCORE_HW_TICKS(10)
  ) dut (
    .clk_i(clk),
    .a_rst_n_i(rst_n),
    .start_stb_i(start),
    .shot_stb_i(shot),
    .game_pause_i(pause),
    .frac_i(frac),
    .game_res_stb_o(res_o),
    .game_btn_stb_o(btn_o),
    .round_o(round_o),
    .hits_o(hits_o),
    .best_dist_o(best_o),
    .total_dist_o(total_o),
    .show_score_o(show_o),
    .match_done_o(done_o)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; start = 0; shot = 0;
    pause = 0; frac = 7'd0;
    tick(); tick();
    chk("rst_round", 32'(round_o), 0);
    chk("rst_hits", 32'(hits_o), 0);
    chk("rst_best", 32'(best_o), 32'h7F);
    chk("rst_total", 32'(total_o), 0);
    chk("rst_show", 32'(show_o), 0);
    chk("rst_done", 32'(done_o), 0);
    chk("rst_res", 32'(res_o), 0);
    rst_n = 1'b1;
    tick();
    shot = 1; tick(); shot = 0;
    chk("idle_shot", 32'(btn_o), 0);

    start = 1; tick(); start = 0;
    chk("start_res", 32'(res_o), 1);
    chk("start_round", 32'(round_o), 0);
    chk("start_best", 32'(best_o), 32'h7F);
    tick();
    chk("res_1cyc", 32'(res_o), 0);
    shot = 1; tick(); shot = 0;
    chk("armed_shot", 32'(btn_o), 1);
    tick();
    chk("btn_1cyc", 32'(btn_o), 0);

    // round 1: frac 0 -> hit
    frac = 7'd0; pause = 1; tick();
    chk("r1_hits", 32'(hits_o), 1);
    chk("r1_best", 32'(best_o), 0);
    chk("r1_total", 32'(total_o), 0);
    tick();
    shot = 1; tick(); shot = 0;
    chk("hold_shot", 32'(btn_o), 0);
    pause = 0; tick();
    chk("r1_round", 32'(round_o), 1);
    chk("r1_show", 32'(show_o), 0);
    shot = 1; tick(); shot = 0;
    chk("run_shot", 32'(btn_o), 1);

    // round 2: frac 3 -> dist 3
    frac = 7'd3; pause = 1; tick();
    chk("r2_total", 32'(total_o), 3);
    chk("r2_best", 32'(best_o), 0);
    chk("r2_hits", 32'(hits_o), 1);
    pause = 0; tick();
    chk("r2_round", 32'(round_o), 2);

    // round 3: frac 97 -> dist 3
    frac = 7'd97; pause = 1; tick();
    chk("r3_total", 32'(total_o), 6);
    chk("r3_best", 32'(best_o), 0);
    pause = 0; tick();
    chk("r3_round", 32'(round_o), 3);
    chk("r3_show", 32'(show_o), 1);
    for (int i = 1; i < 10; i++) begin
      tick();
      chk($sformatf("show_c%0d", i), 32'(show_o), 1);
      chk($sformatf("ndone_c%0d", i), 32'(done_o), 0);
    end
    tick();
    chk("show_end", 32'(show_o), 0);
    chk("done", 32'(done_o), 1);
    shot = 1; tick(); shot = 0;
    chk("done_shot", 32'(btn_o), 0);
    chk("done_round", 32'(round_o), 3);
    chk("done_total", 32'(total_o), 6);
    chk("done_hits", 32'(hits_o), 1);

    // second match: dist 50 then clamped 120 -> 1
    start = 1; tick(); start = 0;
    chk("m2_res", 32'(res_o), 1);
    chk("m2_round", 32'(round_o), 0);
    chk("m2_hits", 32'(hits_o), 0);
    chk("m2_total", 32'(total_o), 0);
    chk("m2_best", 32'(best_o), 32'h7F);
    chk("m2_done", 32'(done_o), 0);
    shot = 1; tick(); shot = 0;
    frac = 7'd50; pause = 1; tick();
    chk("f50_total", 32'(total_o), 50);
    chk("f50_best", 32'(best_o), 50);
    pause = 0; tick();
    frac = 7'd120; pause = 1; tick();
    chk("f120_total", 32'(total_o), 51);
    chk("f120_best", 32'(best_o), 1);
    chk("f120_hits", 32'(hits_o), 0);
    tick();

    // start + shot mid-HOLD
    start = 1; shot = 1; tick();
    start = 0; shot = 0;
    chk("ab_res", 32'(res_o), 1);
    chk("ab_btn", 32'(btn_o), 0);
    chk("ab_round", 32'(round_o), 0);
    chk("ab_total", 32'(total_o), 0);
    chk("ab_best", 32'(best_o), 32'h7F);
    tick();
    chk("ab_res1", 32'(res_o), 0);
    pause = 0; tick();
    chk("armed_fall", 32'(round_o), 0);

    // start + pause rise in RUNNING: rise ignored
    shot = 1; tick(); shot = 0;
    frac = 7'd5; pause = 1; start = 1; tick();
    start = 0;
    chk("se_res", 32'(res_o), 1);
    chk("se_total", 32'(total_o), 0);
    chk("se_best", 32'(best_o), 32'h7F);
    pause = 0; tick();

    // async reset mid-match
    shot = 1; tick(); shot = 0;
    frac = 7'd10; pause = 1; tick();
    chk("pre_total", 32'(total_o), 10);
    #2 rst_n = 1'b0; #1;
    chk("ar_total", 32'(total_o), 0);
    chk("ar_best", 32'(best_o), 32'h7F);
    chk("ar_res", 32'(res_o), 0);
    pause = 0;
    tick();
    rst_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
